// File: rtl/ram_sp_init.sv
// Single-port RAM with a valid/ready request port, pipelined read response and
// a hardware zero-fill sweep after reset or clear. Optional parity: RAM_SP_INIT_PARITY_EN.
module ram_sp_init #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef RAM_SP_INIT_PARITY_EN
  input  logic              inj_perr,
  output logic              rsp_perr,
`endif
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_busy
);

`ifdef RAM_SP_INIT_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int MEM_W = DATA_W + PAR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [MEM_W-1:0]  mem [2**ADDR_W];
  logic [MEM_W-1:0]  wr_word;
  logic              accept;
  logic              rd_accept;
  logic [RD_LAT-1:0] vld;
  logic [MEM_W-1:0]  dat [RD_LAT];

  assign req_ready = (state == RUN) && !clear;
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_we;
  assign init_busy = (state == INIT);

`ifdef RAM_SP_INIT_PARITY_EN
  // Even parity: the stored bit makes the whole word XOR to zero.
  assign wr_word  = {(^req_wdata) ^ inj_perr, req_wdata};
  assign rsp_perr = ^dat[RD_LAT-1];
`else
  assign wr_word  = req_wdata;
`endif

  assign rsp_valid = vld[RD_LAT-1];
  assign rsp_rdata = dat[RD_LAT-1][DATA_W-1:0];

  // Pointer stops at the last address, so a finished sweep never re-runs on its own.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      ptr   <= '0;
    end else if (clear) begin
      state <= INIT;
      ptr   <= '0;
    end else if (state == INIT) begin
      if (ptr == LAST_ADDR) state <= RUN;
      else                  ptr   <= ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (state == INIT && !clear) mem[ptr] <= '0;
    else if (accept && req_we)   mem[req_addr] <= wr_word;
  end

  // Data stages load only on a valid beat, so the output holds between responses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) dat[i] <= '0;
    end else begin
      vld[0] <= rd_accept;
      if (rd_accept) dat[0] <= mem[req_addr];
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

endmodule
